corevx_mem_arbiter: RTL and testbench
=====================================

Name: corevx_mem_arbiter

Overview:
- Downstream neighbour of the cache bypass unit.
- Arbitrates between two masters for the single external memory port:
  - c_*: cache refill/writeback, burst-capable.
  - b_*: bypass, single beat.
- Locks ownership across read bursts, write bursts and write responses. Routes readdata, readdatavalid and response back to the owner only.

Parameters:
- ADDR_W, 34, address width.
- DATA_W, 32, data width.
- BURST_W, 4, burstcount width (max burst 2^BURST_W-1).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- x_address  in  ADDR_W  request address (x = c, b; one set per master).
- x_read, x_write  in  1  request strobes (never both set).
- x_writedata  in  DATA_W  write data.
- x_byteenable  in  DATA_W/8  byte enables.
- x_burstcount  in  BURST_W  beats; 0 treated as 1; b_burstcount is tied to 1.
- x_waitrequest  out  1  stall to master x.
- x_readdata  out  DATA_W  read data.
- x_readdatavalid  out  1  read beat valid.
- x_writeresponsevalid  out  1  write response valid.
- x_response  out  2  response code, valid with readdatavalid/writeresponsevalid.
- m_address, m_read, m_write, m_writedata, m_byteenable, m_burstcount  out  (widths as above)  memory request.
- m_waitrequest  in  1  memory stall.
- m_readdata  in  DATA_W  memory read data.
- m_readdatavalid  in  1  memory read beat valid.
- m_writeresponsevalid  in  1  memory write response valid.
- m_response  in  2  memory response code.

Behaviour:
- States: IDLE, RD_WAIT, WR_BURST, WR_RESP.
- Registers: owner (0 = c, 1 = b), last_grant, beat counter (BURST_W bits).
- Reset values:
  - state = IDLE, last_grant = 1 (c wins first tie), counter = 0.
  - All m_read/m_write and x_readdatavalid/x_writeresponsevalid = 0.
  - x_waitrequest = 1.
- IDLE:
  - Combinational grant. Only one master requesting → it wins. Both requesting → the one != last_grant wins.
  - Granted master's request drives m_* in the same cycle (zero-latency pass-through).
  - Granted x_waitrequest = m_waitrequest; the other x_waitrequest = 1.
  - No request → m_read = m_write = 0.
- Read accepted (m_read & !m_waitrequest):
  - owner := grantee, last_grant := grantee, counter := eff_burst.
  - Go RD_WAIT.
- Write accepted:
  - owner := grantee, last_grant := grantee.
  - eff_burst = 1 → WR_RESP.
  - eff_burst > 1 → counter := eff_burst-1, go WR_BURST.
- RD_WAIT:
  - m_read = m_write = 0; both x_waitrequest = 1.
  - Each m_readdatavalid: decrement counter; route readdata/response to owner.
  - Beat with counter == 1 → IDLE; new grant possible the next cycle, not the same cycle.
- WR_BURST:
  - Only owner's x_write/writedata/byteenable pass through; owner waitrequest = m_waitrequest; other = 1.
  - m_burstcount is held at the value latched on the first beat.
  - Each accepted beat decrements the counter; last beat → WR_RESP.
  - Owner dropping x_write mid-burst: m_write = 0, stay in state.
- WR_RESP:
  - No new requests; both x_waitrequest = 1.
  - m_writeresponsevalid → pulse owner x_writeresponsevalid with response, then IDLE.
- Routing:
  - x_readdatavalid, x_writeresponsevalid: only the owner's may assert.
  - Non-owner readdata/response are don't-care, driven 0.
  - A stray m_readdatavalid or m_writeresponsevalid in IDLE is dropped.
  - Error response (m_response != 0) does not abort the burst; counting continues.
- Reset mid-operation: abandons any transaction, returns to IDLE; in-flight memory beats after reset are dropped.
- No combinational path from m_readdatavalid to any m_* request output.

Test Plan:
- c_read, burstcount = 4, m_waitrequest = 0, four m_readdatavalid beats → c_readdatavalid × 4 with matching data. b_read held meanwhile sees b_waitrequest = 1 until the cycle after the 4th beat.
- c_read and b_read both asserted out of reset → c granted first. Next both-request → b granted (round-robin).
- b_write single beat, m_waitrequest = 1 for 3 cycles then 0, m_writeresponsevalid with response = 2'b10 → b_waitrequest follows m_waitrequest. Exactly one b_writeresponsevalid with response = 2'b10, then IDLE.
- c_write burstcount = 3 with c_write deasserted one cycle between beats 2 and 3 → m_write follows c_write, m_burstcount stays 3, WR_RESP is entered after beat 3 only.
- m_readdatavalid pulse while IDLE → no x_readdatavalid asserted.
- rst asserted during RD_WAIT after 2 of 4 beats → next cycle IDLE, all valids 0. A new b_read is granted the following cycle.

Source files
------------

// File: rtl/corevx_mem_arbiter_if.sv
// Avalon-MM style request/response bundle shared by the two masters
// and the external memory port of corevx_mem_arbiter.
interface corevx_mem_arbiter_if #(
    parameter int ADDR_W  = 34,
    parameter int DATA_W  = 32,
    parameter int BURST_W = 4
);
    logic [ADDR_W-1:0]   address;
    logic                read;
    logic                write;
    logic [DATA_W-1:0]   writedata;
    logic [DATA_W/8-1:0] byteenable;
    logic [BURST_W-1:0]  burstcount;
    logic                waitrequest;
    logic [DATA_W-1:0]   readdata;
    logic                readdatavalid;
    logic                writeresponsevalid;
    logic [1:0]          response;

    modport master (
        output address,
        output read,
        output write,
        output writedata,
        output byteenable,
        output burstcount,
        input  waitrequest,
        input  readdata,
        input  readdatavalid,
        input  writeresponsevalid,
        input  response
    );

    modport slave (
        input  address,
        input  read,
        input  write,
        input  writedata,
        input  byteenable,
        input  burstcount,
        output waitrequest,
        output readdata,
        output readdatavalid,
        output writeresponsevalid,
        output response
    );
endinterface

// File: rtl/corevx_mem_arbiter.sv
// Two-master arbiter (cache refill c, bypass b) for one memory port;
// ownership is held across read bursts, write bursts and write responses.
module corevx_mem_arbiter #(
    parameter int ADDR_W  = 34,
    parameter int DATA_W  = 32,
    parameter int BURST_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    corevx_mem_arbiter_if.slave  c_bus,
    corevx_mem_arbiter_if.slave  b_bus,
    corevx_mem_arbiter_if.master m_bus
);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_RD_WAIT  = 2'd1;
    localparam logic [1:0] S_WR_BURST = 2'd2;
    localparam logic [1:0] S_WR_RESP  = 2'd3;

    localparam logic [BURST_W-1:0] ONE = BURST_W'(1);

    logic [1:0]         state_q, state_d;
    logic               owner_q, owner_d;
    logic               last_q, last_d;
    logic [BURST_W-1:0] cnt_q, cnt_d;
    logic [BURST_W-1:0] bcnt_q, bcnt_d;

    logic st_idle, st_rd, st_wrb, st_wrr;
    logic c_req, b_req, any_req;
    logic gnt_b, sel_b;
    logic sel_read, sel_write;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic [DATA_W/8-1:0] sel_be;
    logic [BURST_W-1:0]  sel_bc, sel_eff;
    logic c_fwd, b_fwd;
    logic c_own, b_own;

    assign st_idle = (state_q == S_IDLE);
    assign st_rd   = (state_q == S_RD_WAIT);
    assign st_wrb  = (state_q == S_WR_BURST);
    assign st_wrr  = (state_q == S_WR_RESP);

    assign c_req   = c_bus.read | c_bus.write;
    assign b_req   = b_bus.read | b_bus.write;
    assign any_req = c_req | b_req;

    // On a tie the master that did not win last time gets the port.
    assign gnt_b = b_req & (~c_req | ~last_q);
    assign sel_b = st_idle ? gnt_b : owner_q;

    assign sel_read  = sel_b ? b_bus.read       : c_bus.read;
    assign sel_write = sel_b ? b_bus.write      : c_bus.write;
    assign sel_addr  = sel_b ? b_bus.address    : c_bus.address;
    assign sel_wdata = sel_b ? b_bus.writedata  : c_bus.writedata;
    assign sel_be    = sel_b ? b_bus.byteenable : c_bus.byteenable;
    assign sel_bc    = sel_b ? b_bus.burstcount : c_bus.burstcount;
    assign sel_eff   = (sel_bc == '0) ? ONE : sel_bc;

    // Request side depends only on state and master inputs, never on
    // returning read beats.
    assign m_bus.address    = sel_addr;
    assign m_bus.writedata  = sel_wdata;
    assign m_bus.byteenable = sel_be;
    assign m_bus.burstcount = st_wrb ? bcnt_q : sel_bc;
    assign m_bus.read       = ~rst & st_idle & sel_read;
    assign m_bus.write      = ~rst & (st_idle | st_wrb) & sel_write;

    assign c_fwd = ~rst & ((st_idle & any_req & ~gnt_b) | (st_wrb & ~owner_q));
    assign b_fwd = ~rst & ((st_idle & gnt_b) | (st_wrb & owner_q));

    assign c_bus.waitrequest = c_fwd ? m_bus.waitrequest : 1'b1;
    assign b_bus.waitrequest = b_fwd ? m_bus.waitrequest : 1'b1;

    assign c_own = ~rst & ~owner_q;
    assign b_own = ~rst & owner_q;

    assign c_bus.readdatavalid = c_own & st_rd & m_bus.readdatavalid;
    assign b_bus.readdatavalid = b_own & st_rd & m_bus.readdatavalid;
    assign c_bus.readdata      = (c_own & st_rd) ? m_bus.readdata : '0;
    assign b_bus.readdata      = (b_own & st_rd) ? m_bus.readdata : '0;

    assign c_bus.writeresponsevalid = c_own & st_wrr & m_bus.writeresponsevalid;
    assign b_bus.writeresponsevalid = b_own & st_wrr & m_bus.writeresponsevalid;

    assign c_bus.response = (c_own & (st_rd | st_wrr)) ? m_bus.response : 2'b00;
    assign b_bus.response = (b_own & (st_rd | st_wrr)) ? m_bus.response : 2'b00;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        bcnt_d  = bcnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (any_req && !m_bus.waitrequest) begin
                    owner_d = gnt_b;
                    last_d  = gnt_b;
                    if (sel_read) begin
                        cnt_d   = sel_eff;
                        state_d = S_RD_WAIT;
                    end else if (sel_eff == ONE) begin
                        state_d = S_WR_RESP;
                    end else begin
                        cnt_d   = sel_eff - ONE;
                        bcnt_d  = sel_bc;
                        state_d = S_WR_BURST;
                    end
                end
            end
            S_RD_WAIT: begin
                // Error responses still count as beats.
                if (m_bus.readdatavalid) begin
                    cnt_d = cnt_q - ONE;
                    if (cnt_q == ONE) begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_WR_BURST: begin
                if (sel_write && !m_bus.waitrequest) begin
                    cnt_d = cnt_q - ONE;
                    if (cnt_q == ONE) begin
                        state_d = S_WR_RESP;
                    end
                end
            end
            S_WR_RESP: begin
                if (m_bus.writeresponsevalid) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            cnt_q   <= '0;
            bcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            bcnt_q  <= bcnt_d;
        end
    end

endmodule

// File: tb/tb_corevx_mem_arbiter.sv
// Directed bench for corevx_mem_arbiter: response beats are checked by a
// queue-based monitor, handshake/request signals by inline checks.
module tb_corevx_mem_arbiter;

    localparam int AW = 34;
    localparam int DW = 32;
    localparam int BW = 4;

    logic clk;
    logic rst;

    corevx_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .BURST_W(BW)) c_if ();
    corevx_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .BURST_W(BW)) b_if ();
    corevx_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .BURST_W(BW)) m_if ();

    corevx_mem_arbiter #(
        .ADDR_W (AW),
        .DATA_W (DW),
        .BURST_W(BW)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .c_bus(c_if.slave),
        .b_bus(b_if.slave),
        .m_bus(m_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int failures;

    // 0: c read, 1: b read, 2: c write resp, 3: b write resp
    logic [33:0] expq [4][$];

    localparam logic [AW-1:0] ADDR_C = 34'h1_0000_0100;
    localparam logic [AW-1:0] ADDR_B = 34'h2_0000_0200;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic mon(input int k, input string nm, input logic [33:0] got);
        logic [33:0] e;
        checks++;
        if (expq[k].size() == 0) begin
            failures++;
            $display("FAIL %s: unexpected valid, got %0h expected none", nm, got);
        end else begin
            e = expq[k].pop_front();
            if (got !== e) begin
                failures++;
                $display("FAIL %s: got %0h expected %0h", nm, got, e);
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (c_if.readdatavalid)
                mon(0, "c_rd", {c_if.readdata, c_if.response});
            if (b_if.readdatavalid)
                mon(1, "b_rd", {b_if.readdata, b_if.response});
            if (c_if.writeresponsevalid)
                mon(2, "c_wr", {32'h0, c_if.response});
            if (b_if.writeresponsevalid)
                mon(3, "b_wr", {32'h0, b_if.response});
        end
    end

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_masters;
        c_if.read = 0; c_if.write = 0; c_if.address = '0;
        c_if.writedata = '0; c_if.byteenable = '0; c_if.burstcount = '0;
        b_if.read = 0; b_if.write = 0; b_if.address = '0;
        b_if.writedata = '0; b_if.byteenable = '0; b_if.burstcount = '0;
    endtask

    task automatic clear_mem;
        m_if.waitrequest = 0; m_if.readdata = '0; m_if.readdatavalid = 0;
        m_if.writeresponsevalid = 0; m_if.response = 2'b00;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1;
        clear_masters();
        clear_mem();
        cyc();
        cyc();

        // reset state, sampled while rst is held
        @(negedge clk);
        chk("rst_c_wait", c_if.waitrequest, 1);
        chk("rst_b_wait", b_if.waitrequest, 1);
        chk("rst_m_rw", {m_if.read, m_if.write}, 0);
        chk("rst_valids", {c_if.readdatavalid, b_if.readdatavalid,
            c_if.writeresponsevalid, b_if.writeresponsevalid}, 0);
        cyc();
        rst = 0;

        // both read out of reset: c first, then b via round robin
        c_if.read = 1; c_if.address = ADDR_C; c_if.burstcount = 4;
        b_if.read = 1; b_if.address = ADDR_B; b_if.burstcount = 1;
        @(negedge clk);
        chk("t1_m_read", m_if.read, 1);
        chk("t1_m_addr", m_if.address, ADDR_C);
        chk("t1_m_bc", m_if.burstcount, 4);
        chk("t1_c_wait", c_if.waitrequest, 0);
        chk("t1_b_wait", b_if.waitrequest, 1);
        cyc();
        for (int i = 0; i < 4; i++) begin
            m_if.readdatavalid = 1;
            m_if.readdata = 32'hCAFE_0000 + i;
            m_if.response = (i == 1) ? 2'b10 : 2'b00;
            expq[0].push_back({32'hCAFE_0000 + i, (i == 1) ? 2'b10 : 2'b00});
            @(negedge clk);
            chk("t1_rd_b_wait", b_if.waitrequest, 1);
            chk("t1_rd_m_read", m_if.read, 0);
            cyc();
        end
        clear_mem();
        @(negedge clk);
        chk("t2_rr_addr", m_if.address, ADDR_B);
        chk("t2_rr_b_wait", b_if.waitrequest, 0);
        chk("t2_rr_c_wait", c_if.waitrequest, 1);
        chk("t2_rr_m_read", m_if.read, 1);
        chk("t2_rr_bc", m_if.burstcount, 1);
        cyc();
        clear_masters();
        m_if.readdatavalid = 1; m_if.readdata = 32'h1234_5678;
        expq[1].push_back({32'h1234_5678, 2'b00});
        cyc();
        clear_mem();

        // b single write with memory stall, error response
        b_if.write = 1; b_if.address = ADDR_B; b_if.burstcount = 1;
        b_if.writedata = 32'hB00B_0001; b_if.byteenable = 4'hF;
        m_if.waitrequest = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t3_m_write", m_if.write, 1);
            chk("t3_b_wait_hi", b_if.waitrequest, 1);
            chk("t3_m_wdata", m_if.writedata, 32'hB00B_0001);
            cyc();
        end
        m_if.waitrequest = 0;
        @(negedge clk);
        chk("t3_b_wait_lo", b_if.waitrequest, 0);
        cyc();
        clear_masters();
        @(negedge clk);
        chk("t3_resp_b_wait", b_if.waitrequest, 1);
        chk("t3_resp_m_write", m_if.write, 0);
        cyc();
        m_if.writeresponsevalid = 1; m_if.response = 2'b10;
        expq[3].push_back({32'h0, 2'b10});
        cyc();
        clear_mem();
        b_if.read = 1; b_if.address = ADDR_B; b_if.burstcount = 1;
        @(negedge clk);
        chk("t3_idle_regrant", b_if.waitrequest, 0);
        clear_masters();
        cyc();

        // c write burst of 3 with a one-cycle gap before beat 3
        c_if.write = 1; c_if.address = ADDR_C; c_if.burstcount = 3;
        c_if.byteenable = 4'hF; c_if.writedata = 32'hD000_0001;
        @(negedge clk);
        chk("t4_b1_write", m_if.write, 1);
        chk("t4_b1_bc", m_if.burstcount, 3);
        cyc();
        c_if.writedata = 32'hD000_0002; c_if.burstcount = 0;
        @(negedge clk);
        chk("t4_b2_write", m_if.write, 1);
        chk("t4_b2_bc", m_if.burstcount, 3);
        chk("t4_b2_wdata", m_if.writedata, 32'hD000_0002);
        cyc();
        c_if.write = 0;
        @(negedge clk);
        chk("t4_gap_write", m_if.write, 0);
        chk("t4_gap_bc", m_if.burstcount, 3);
        cyc();
        c_if.write = 1; c_if.writedata = 32'hD000_0003;
        @(negedge clk);
        chk("t4_b3_write", m_if.write, 1);
        chk("t4_b3_c_wait", c_if.waitrequest, 0);
        cyc();
        clear_masters();
        @(negedge clk);
        chk("t4_resp_c_wait", c_if.waitrequest, 1);
        cyc();
        m_if.writeresponsevalid = 1; m_if.response = 2'b00;
        expq[2].push_back({32'h0, 2'b00});
        cyc();
        clear_mem();

        // stray memory valids while idle are dropped
        m_if.readdatavalid = 1; m_if.readdata = 32'hDEAD_BEEF;
        m_if.writeresponsevalid = 1; m_if.response = 2'b11;
        @(negedge clk);
        chk("t5_stray", {c_if.readdatavalid, b_if.readdatavalid,
            c_if.writeresponsevalid, b_if.writeresponsevalid}, 0);
        cyc();
        clear_mem();

        // reset during a c read burst after 2 of 4 beats
        c_if.read = 1; c_if.address = ADDR_C; c_if.burstcount = 4;
        cyc();
        clear_masters();
        for (int i = 0; i < 2; i++) begin
            m_if.readdatavalid = 1; m_if.readdata = 32'h5500_0000 + i;
            expq[0].push_back({32'h5500_0000 + i, 2'b00});
            cyc();
        end
        rst = 1;
        m_if.readdata = 32'h5500_0002;
        cyc();
        rst = 0;
        m_if.readdata = 32'h5500_0003;
        b_if.read = 1; b_if.address = ADDR_B; b_if.burstcount = 1;
        @(negedge clk);
        chk("t6_valids", {c_if.readdatavalid, b_if.readdatavalid}, 0);
        chk("t6_m_read", m_if.read, 1);
        chk("t6_m_addr", m_if.address, ADDR_B);
        chk("t6_b_wait", b_if.waitrequest, 0);
        cyc();
        clear_masters();
        clear_mem();
        cyc();
        m_if.readdatavalid = 1; m_if.readdata = 32'h7777_0001;
        expq[1].push_back({32'h7777_0001, 2'b00});
        cyc();
        clear_mem();
        cyc();
        cyc();

        chk("pending_exp", expq[0].size() + expq[1].size()
            + expq[2].size() + expq[3].size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
